tone_transmitter: RTL and testbench

Junction-beacon tone generator. Accepts a direction command in the 3-bit direction code used by the tone-detection receiver and emits a square-wave tone burst at the frequency assigned to that direction, followed by a mandatory silent gap. The gap lets the receiver's post-detection hold expire before the next burst. Drives the speaker/line output feeding the bandpass filter bank on the robot side.

---
 rtl/tone_pkg.sv | 17 +
 rtl/tone_divider.sv | 35 +++
 rtl/tone_transmitter.sv | 119 +++++++++++
 tb/tb_tone_transmitter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: direction codes shared by the beacon transmitter and the tone-detection receiver,
// plus the transmitter state encoding.
package tone_pkg;

    localparam logic [2:0] DIR_STRAIGHT = 3'b000;
    localparam logic [2:0] DIR_LEFT     = 3'b001;
    localparam logic [2:0] DIR_RIGHT    = 3'b010;
    localparam logic [2:0] DIR_BACK     = 3'b011;
    localparam logic [2:0] DIR_STOP     = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/tone_divider.sv
// tone_divider: half-period phase counter driving a registered square wave.
// clr starts a fresh high phase; dropping en forces the output low.
module tone_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] half,
    output logic        sq
);

    logic [31:0] r_phase;
    logic        r_sq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_sq    <= 1'b0;
        end else if (clr) begin
            r_phase <= '0;
            r_sq    <= 1'b1;
        end else if (!en) begin
            r_phase <= '0;
            r_sq    <= 1'b0;
        end else if (r_phase == half - 32'd1) begin
            r_phase <= '0;
            r_sq    <= ~r_sq;
        end else begin
            r_phase <= r_phase + 32'd1;
        end
    end

    assign sq = r_sq;

endmodule

// File: rtl/tone_transmitter.sv
// tone_transmitter: junction beacon emitting a direction-coded tone burst followed by a
// silent gap long enough for the receiver's post-detection hold to expire.
module tone_transmitter
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned HALF_STRAIGHT = 25_000,
    parameter int unsigned HALF_LEFT     = 12_500,
    parameter int unsigned HALF_RIGHT    = 8_333,
    parameter int unsigned HALF_BACK     = 6_250,
    parameter int unsigned BURST_CYCLES  = 25_000_000,
    parameter int unsigned GAP_CYCLES    = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_dir,
    output logic       cmd_ready,
    input  logic       abort,
    output logic       tone_out,
    output logic       tone_en,
    output logic [1:0] tone_sel,
    output logic       busy,
    output logic       done
);

    tx_state_t   r_state;
    logic [31:0] r_cnt;
    logic        r_tone_en;
    logic [1:0]  r_tone_sel;
    logic        r_busy;
    logic        r_done;
    logic        w_start;
    logic        w_burst_last;
    logic        w_gap_last;
    logic        w_div_en;
    logic [31:0] w_half;
    logic        w_sq;

    assign cmd_ready    = (r_state == ST_IDLE);
    assign w_start      = cmd_valid && cmd_ready && !cmd_dir[2];
    assign w_burst_last = (r_cnt == 32'(BURST_CYCLES - 1));
    assign w_gap_last   = (r_cnt == 32'(GAP_CYCLES - 1));
    // Divider keeps running only while the burst continues past this edge.
    assign w_div_en     = (r_state == ST_BURST) && !abort && !w_burst_last;
    assign w_half       = ({1'b0, r_tone_sel} == DIR_LEFT)  ? 32'(HALF_LEFT)  :
                          ({1'b0, r_tone_sel} == DIR_RIGHT) ? 32'(HALF_RIGHT) :
                          ({1'b0, r_tone_sel} == DIR_BACK)  ? 32'(HALF_BACK)  :
                                                              32'(HALF_STRAIGHT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_tone_en  <= 1'b0;
            r_tone_sel <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_BURST;
                        r_cnt      <= '0;
                        r_tone_en  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_tone_sel <= cmd_dir[1:0];
                    end
                end
                ST_BURST: begin
                    if (abort) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_tone_en <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (w_burst_last) begin
                        r_state   <= ST_GAP;
                        r_cnt     <= '0;
                        r_tone_en <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_gap_last) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    tone_divider u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start),
        .en    (w_div_en),
        .half  (w_half),
        .sq    (w_sq)
    );

    assign tone_out = w_sq;
    assign tone_en  = r_tone_en;
    assign tone_sel = r_tone_sel;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_tone_transmitter.sv
// tb_tone_transmitter: directed checks of burst shape, gap, done timing, STOP, abort and async reset.
module tb_tone_transmitter;
    import tone_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_dir = 3'b000;
    logic       abort = 1'b0;
    logic       cmd_ready;
    logic       tone_out;
    logic       tone_en;
    logic [1:0] tone_sel;
    logic       busy;
    logic       done;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    tone_transmitter #(
        .HALF_STRAIGHT (4),
        .HALF_LEFT     (3),
        .HALF_RIGHT    (2),
        .HALF_BACK     (1),
        .BURST_CYCLES  (20),
        .GAP_CYCLES    (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_ready (cmd_ready),
        .abort     (abort),
        .tone_out  (tone_out),
        .tone_en   (tone_en),
        .tone_sel  (tone_sel),
        .busy      (busy),
        .done      (done)
    );

    // status word: {cmd_ready, tone_out, tone_en, busy, done}
    function automatic logic [4:0] st();
        return {cmd_ready, tone_out, tone_en, busy, done};
    endfunction

    function automatic logic [4:0] burst_st(input logic t);
        return {1'b0, t, 3'b110};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_state", 32'({st(), tone_sel}), 32'({5'b10000, 2'b00}));
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk("idle_after_reset", 32'(st()), 32'(5'b10000));
        end

        cmd_dir = DIR_LEFT; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("left_sel", 32'(tone_sel), 32'(2'b01));
        for (int k = 0; k < 20; k++) begin
            chk("left_burst", 32'(st()), 32'(burst_st((k % 6) < 3)));
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            chk("left_gap", 32'(st()), 32'(5'b00010));
            @(negedge clk);
        end
        chk("left_done", 32'(st()), 32'(5'b10001));
        @(negedge clk);
        chk("left_after_done", 32'(st()), 32'(5'b10000));

        cmd_dir = DIR_STOP; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stop_idle", 32'(st()), 32'(5'b10000));
            @(negedge clk);
        end
        chk("stop_keeps_sel", 32'(tone_sel), 32'(2'b01));

        cmd_dir = DIR_BACK; cmd_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 62; k++) begin
            int p;
            p = k % 31;
            if (p < 20) chk("back_burst", 32'(st()), 32'(burst_st((p % 2) == 0)));
            else if (p < 30) chk("back_gap", 32'(st()), 32'(5'b00010));
            else chk("back_done", 32'(st()), 32'(5'b10001));
            if (p == 0) chk("back_sel", 32'(tone_sel), 32'(2'b11));
            @(negedge clk);
        end
        chk("back_third_start", 32'(st()), 32'(burst_st(1'b1)));
        cmd_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("back_abort", 32'(st()), 32'(5'b10000));

        cmd_dir = DIR_STRAIGHT; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("straight_sel", 32'(tone_sel), 32'(2'b00));
        for (int k = 0; k < 6; k++) begin
            chk("straight_burst", 32'(st()), 32'(burst_st(((k / 4) % 2) == 0)));
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("straight_abort", 32'(st()), 32'(5'b10000));
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("straight_no_done", 32'(done), 32'(1'b0));
        end

        cmd_dir = DIR_RIGHT; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (23) @(negedge clk);
        chk("right_mid_gap", 32'({st(), tone_sel}), 32'({5'b00010, 2'b10}));
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'({st(), tone_sel}), 32'({5'b10000, 2'b00}));
        @(negedge clk);
        rst_n = 1'b1;
        cmd_dir = DIR_RIGHT; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("right2_sel", 32'(tone_sel), 32'(2'b10));
        for (int k = 0; k < 20; k++) begin
            chk("right2_burst", 32'(st()), 32'(burst_st(((k / 2) % 2) == 0)));
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            chk("right2_gap", 32'(st()), 32'(5'b00010));
            @(negedge clk);
        end
        chk("right2_done", 32'(st()), 32'(5'b10001));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
